umips_hazard_ctrl: RTL and testbench
====================================

Name: umips_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage umips pipeline (F/D/E/M/W).
- Generates stall/flush enables for every pipeline register, including the M->W register, and operand-forwarding selects for D and E.
- Sequences multi-cycle data-memory accesses through a wait FSM with timeout.
- Purely control; drives no datapath values.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before mem_err asserts; range 2..255.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- rs_d, rt_d  in  5 each  source regs of the instruction in D.
- rs_e, rt_e  in  5 each  source regs in E.
- write_reg_e, write_reg_m, write_reg_w  in  5 each  destination reg per stage.
- reg_write_e, reg_write_m, reg_write_w  in  1 each  stage writes the register file.
- mem_to_reg_e, mem_to_reg_m  in  1 each  stage holds a load.
- branch_d  in  1  branch/jr in D needs operands.
- branch_taken_d  in  1  resolved taken branch or jump in D.
- mem_req_m  in  1  M issues a data-memory access.
- mem_ready_m  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register.
- flush_d, flush_e, flush_w  out  1 each  load a bubble (all controls zero).
- fwd_a_d, fwd_b_d  out  1 each  D compare operand taken from M alu_out.
- fwd_a_e, fwd_b_e  out  2 each  00 regfile/ID-EX, 01 W result, 10 M alu_out.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- The clock is clk and the reset is rst. Reset is synchronous and active-high.
- On reset: FSM enters RUN, the wait counter clears and mem_err=0. All stall/flush outputs evaluate to 0 because they are combinational on inputs with FSM=RUN.
- Register 0 never matches for forwarding or hazard detection.

Forwarding (combinational, zero latency):
- fwd_a_e=10 if rs_e!=0 && reg_write_m && write_reg_m==rs_e.
- Else fwd_a_e=01 if rs_e!=0 && reg_write_w && write_reg_w==rs_e.
- Else fwd_a_e=00.
- M takes priority over W. The same rules apply to rt_e/fwd_b_e.
- fwd_a_d=1 iff rs_d!=0 && reg_write_m && write_reg_m==rs_d && !mem_to_reg_m. fwd_b_d is the same with rt_d.

Load-use hazard:
- lw_stall = mem_to_reg_e && (write_reg_e==rs_d || write_reg_e==rt_d), with write_reg_e!=0.

Branch hazard:
- br_stall = branch_d && ((reg_write_e && write_reg_e in {rs_d,rt_d}) || (mem_to_reg_m && write_reg_m in {rs_d,rt_d})), with the destination !=0.

FSM, states RUN and MEM_WAIT:
- RUN -> MEM_WAIT when mem_req_m && !mem_ready_m. The counter loads 1.
- MEM_WAIT -> RUN when mem_ready_m.
- In MEM_WAIT the counter increments each cycle and saturates at MEM_TIMEOUT.
- When the counter reaches MEM_TIMEOUT: mem_err sets (sticky until rst) and the FSM forces a return to RUN the next cycle. The access is abandoned; M proceeds as if ready.
- mem_busy = (mem_req_m && !mem_ready_m) in RUN, or !mem_ready_m && !timeout in MEM_WAIT. A single-cycle access (ready with req) causes no stall.

Output priority (highest first):
- mem_busy: stall_f=stall_d=stall_e=stall_m=1, flush_w=1. No other flush is asserted.
- lw_stall or br_stall: stall_f=stall_d=1, flush_e=1.
- branch_taken_d: flush_d=1.
- Otherwise all outputs are 0.
- A branch_taken_d that coincides with any stall is ignored; it is re-evaluated when D advances.
- rst asserted mid-MEM_WAIT returns to RUN on that edge and deasserts every stall/flush.

Optional Feature:
- Macro: UMIPS_HAZARD_STATS_EN.
- When defined, adds 32-bit outputs stat_stall_cycles, stat_flush_count and stat_mem_wait_cycles:
  - stat_stall_cycles increments on any cycle with stall_f=1.
  - stat_flush_count increments once per cycle with flush_d||flush_e=1.
  - stat_mem_wait_cycles increments each cycle in MEM_WAIT.
  - All three clear on rst and wrap at 2^32.
- When undefined, these ports and their logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package umips_pkg holds:
  - FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the FSM state encoding HZ_RUN and HZ_MEM_WAIT;
  - REG_ZERO=5'd0.
- One natural sub-module: umips_fwd_unit, combinational forwarding-select logic for D and E. The FSM and priority logic stay in umips_hazard_ctrl.

Test Plan:
1. Forwarding priority: rs_e=5, write_reg_m=5 with reg_write_m=1, and write_reg_w=5 with reg_write_w=1 -> fwd_a_e=10. Drop reg_write_m -> fwd_a_e=01. With rs_e=0 -> fwd_a_e=00.
2. Load-use: mem_to_reg_e=1, write_reg_e=8, rt_d=8 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. No stall when write_reg_e=0.
3. Branch: branch_d=1, rs_d=3, reg_write_e=1, write_reg_e=3 -> stall. Next cycle, with the ALU op in M, fwd_a_d=1 and no stall. Then branch_taken_d=1 -> flush_d=1.
4. Memory wait: mem_req_m=1, mem_ready_m=0 for 4 cycles then 1 -> stall_f/d/e/m and flush_w high for 4 cycles. FSM returns to RUN. mem_err=0.
5. Timeout (MEM_TIMEOUT=16): mem_ready_m held 0 -> mem_err rises after 16 wait cycles and stays high. Stalls drop the following cycle.
6. Reset mid-wait: assert rst during MEM_WAIT -> next edge: all stalls/flushes=0, mem_err=0, FSM=RUN. Simultaneous branch_taken_d and lw_stall -> flush_d=0.

Source files
------------

// File: rtl/umips_pkg.sv
// Shared definitions for the umips pipeline control blocks: forwarding-select
// encodings, hazard FSM state encoding, the zero register and a register-match
// helper that never matches register 0.
package umips_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;

   localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
   localparam logic [FWD_W-1:0] FWD_WB      = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEM     = 2'b10;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      HZ_RUN      = 1'b0,
      HZ_MEM_WAIT = 1'b1
   } hz_state_e;

   // True when a non-zero destination register equals a source register.
   function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] src);
      return (dst != REG_ZERO) && (dst == src);
   endfunction

endpackage

// File: rtl/umips_fwd_unit.sv
// Combinational operand-forwarding selects for the D and E stages.
// Ports:
//   rs_d_i, rt_d_i, rs_e_i, rt_e_i   source registers in D and E
//   write_reg_m_i, write_reg_w_i     destinations in M and W
//   reg_write_m_i, reg_write_w_i     M/W write the register file
//   mem_to_reg_m_i                   M holds a load (alu_out not the result)
//   fwd_a_d_o, fwd_b_d_o             D compare operand from M alu_out
//   fwd_a_e_o, fwd_b_e_o             E operand select (FWD_* encoding)
module umips_fwd_unit
   import umips_pkg::*;
(
   input  logic [REG_W-1:0] rs_d_i,
   input  logic [REG_W-1:0] rt_d_i,
   input  logic [REG_W-1:0] rs_e_i,
   input  logic [REG_W-1:0] rt_e_i,
   input  logic [REG_W-1:0] write_reg_m_i,
   input  logic [REG_W-1:0] write_reg_w_i,
   input  logic             reg_write_m_i,
   input  logic             reg_write_w_i,
   input  logic             mem_to_reg_m_i,
   output logic             fwd_a_d_o,
   output logic             fwd_b_d_o,
   output logic [FWD_W-1:0] fwd_a_e_o,
   output logic [FWD_W-1:0] fwd_b_e_o
);

   // E-stage select: the younger result in M wins over W.
   function automatic logic [FWD_W-1:0] sel_e(input logic [REG_W-1:0] src);
      if (reg_write_m_i && reg_hit(write_reg_m_i, src)) begin
         return FWD_MEM;
      end else if (reg_write_w_i && reg_hit(write_reg_w_i, src)) begin
         return FWD_WB;
      end
      return FWD_REGFILE;
   endfunction

   always_comb begin
      fwd_a_e_o = sel_e(rs_e_i);
      fwd_b_e_o = sel_e(rt_e_i);
      // A load in M has no value yet; branch stall logic covers that case.
      fwd_a_d_o = reg_write_m_i && !mem_to_reg_m_i && reg_hit(write_reg_m_i, rs_d_i);
      fwd_b_d_o = reg_write_m_i && !mem_to_reg_m_i && reg_hit(write_reg_m_i, rt_d_i);
   end

endmodule

// File: rtl/umips_hazard_ctrl.sv
// Central hazard controller for the 5-stage umips pipeline: stall/flush
// enables, forwarding selects, and a data-memory wait FSM with timeout.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rs_d, rt_d, rs_e, rt_e            source registers in D and E
//   write_reg_e/m/w, reg_write_e/m/w  destination and write enable per stage
//   mem_to_reg_e/m                    stage holds a load
//   branch_d, branch_taken_d          branch needs operands / resolved taken
//   mem_req_m, mem_ready_m            data-memory handshake from M
//   stall_f/d/e/m, flush_d/e/w        pipeline register controls
//   fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e forwarding selects
//   mem_err                           sticky memory-timeout flag (registered)
// Optional build macro UMIPS_HAZARD_STATS_EN adds stat_stall_cycles,
// stat_flush_count and stat_mem_wait_cycles counters.
module umips_hazard_ctrl
   import umips_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 8   // 2**CNT_W must exceed MEM_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rs_d,
   input  logic [REG_W-1:0] rt_d,
   input  logic [REG_W-1:0] rs_e,
   input  logic [REG_W-1:0] rt_e,
   input  logic [REG_W-1:0] write_reg_e,
   input  logic [REG_W-1:0] write_reg_m,
   input  logic [REG_W-1:0] write_reg_w,
   input  logic             reg_write_e,
   input  logic             reg_write_m,
   input  logic             reg_write_w,
   input  logic             mem_to_reg_e,
   input  logic             mem_to_reg_m,
   input  logic             branch_d,
   input  logic             branch_taken_d,
   input  logic             mem_req_m,
   input  logic             mem_ready_m,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic             fwd_a_d,
   output logic             fwd_b_d,
   output logic [FWD_W-1:0] fwd_a_e,
   output logic [FWD_W-1:0] fwd_b_e,
   output logic             mem_err
`ifdef UMIPS_HAZARD_STATS_EN
   ,
   output logic [31:0]      stat_stall_cycles,
   output logic [31:0]      stat_flush_count,
   output logic [31:0]      stat_mem_wait_cycles
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             mem_busy, timeout, lw_stall, br_stall;

   umips_fwd_unit u_fwd (
      .rs_d_i        (rs_d),
      .rt_d_i        (rt_d),
      .rs_e_i        (rs_e),
      .rt_e_i        (rt_e),
      .write_reg_m_i (write_reg_m),
      .write_reg_w_i (write_reg_w),
      .reg_write_m_i (reg_write_m),
      .reg_write_w_i (reg_write_w),
      .mem_to_reg_m_i(mem_to_reg_m),
      .fwd_a_d_o     (fwd_a_d),
      .fwd_b_d_o     (fwd_b_d),
      .fwd_a_e_o     (fwd_a_e),
      .fwd_b_e_o     (fwd_b_e)
   );

   // Data hazards that need D held and a bubble injected into E.
   always_comb begin
      lw_stall = mem_to_reg_e &&
                 (reg_hit(write_reg_e, rs_d) || reg_hit(write_reg_e, rt_d));
      br_stall = branch_d &&
                 ((reg_write_e  && (reg_hit(write_reg_e, rs_d) || reg_hit(write_reg_e, rt_d))) ||
                  (mem_to_reg_m && (reg_hit(write_reg_m, rs_d) || reg_hit(write_reg_m, rt_d))));
   end

   // Memory wait FSM next state, counter and busy decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
      mem_busy  = 1'b0;
      timeout   = 1'b0;
      unique case (state_q)
         HZ_RUN: begin
            if (mem_req_m && !mem_ready_m) begin
               state_d  = HZ_MEM_WAIT;
               cnt_d    = CNT_W'(1);
               mem_busy = 1'b1;
            end
         end
         HZ_MEM_WAIT: begin
            // A completion in the final cycle still counts as on time.
            timeout = (cnt_q == TIMEOUT_CNT) && !mem_ready_m;
            if (mem_ready_m || timeout) begin
               state_d = HZ_RUN;
               cnt_d   = '0;
            end else begin
               mem_busy = 1'b1;
               if (cnt_q != TIMEOUT_CNT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            if (timeout) begin
               mem_err_d = 1'b1;
            end
         end
         default: state_d = HZ_RUN;
      endcase
   end

   // Stall/flush priority: memory wait, then data hazards, then taken branch.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (rst) begin
         // Pipeline is being reset; release every hold.
      end else if (mem_busy) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (lw_stall || br_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end else if (branch_taken_d) begin
         flush_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HZ_RUN;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

`ifdef UMIPS_HAZARD_STATS_EN
   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cycles    <= '0;
         stat_flush_count     <= '0;
         stat_mem_wait_cycles <= '0;
      end else begin
         if (stall_f)                  stat_stall_cycles    <= stat_stall_cycles + 32'd1;
         if (flush_d || flush_e)       stat_flush_count     <= stat_flush_count + 32'd1;
         if (state_q == HZ_MEM_WAIT)   stat_mem_wait_cycles <= stat_mem_wait_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_umips_hazard_ctrl.sv
// Directed self-checking bench for umips_hazard_ctrl (MEM_TIMEOUT=16).
module tb_umips_hazard_ctrl;
   import umips_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
   logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
   logic       branch_d, branch_taken_d, mem_req_m, mem_ready_m;
   logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
   logic       fwd_a_d, fwd_b_d, mem_err;
   logic [1:0] fwd_a_e, fwd_b_e;
`ifdef UMIPS_HAZARD_STATS_EN
   logic [31:0] stat_stall_cycles, stat_flush_count, stat_mem_wait_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   umips_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
      .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
      .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
      .branch_d(branch_d), .branch_taken_d(branch_taken_d),
      .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
      .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
      .mem_err(mem_err)
`ifdef UMIPS_HAZARD_STATS_EN
      ,
      .stat_stall_cycles(stat_stall_cycles),
      .stat_flush_count(stat_flush_count),
      .stat_mem_wait_cycles(stat_mem_wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and land just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
      write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
      reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
      mem_to_reg_e = 0; mem_to_reg_m = 0;
      branch_d = 0; branch_taken_d = 0; mem_req_m = 0; mem_ready_m = 0;
   endtask

   // Packs the seven stall/flush outputs: {f,d,e,m,flush_d,flush_e,flush_w}.
   function automatic logic [31:0] ctl();
      return {25'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
   endfunction

   initial begin
      clear_inputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      #1;
      chk("reset_ctl", ctl(), 32'h00);
      chk("reset_err", 32'(mem_err), 32'd0);
      chk("reset_fwd", {28'd0, fwd_a_e, fwd_b_e}, 32'd0);

      // Forwarding priority
      rs_e = 5; write_reg_m = 5; reg_write_m = 1; write_reg_w = 5; reg_write_w = 1;
      #1 chk("fwd_a_e_mem", 32'(fwd_a_e), 32'd2);
      reg_write_m = 0;
      #1 chk("fwd_a_e_wb", 32'(fwd_a_e), 32'd1);
      rt_e = 5;
      #1 chk("fwd_b_e_wb", 32'(fwd_b_e), 32'd1);
      rs_e = 0; write_reg_w = 0;
      #1 chk("fwd_a_e_r0", 32'(fwd_a_e), 32'd0);
      clear_inputs();
      rs_d = 7; rt_d = 7; write_reg_m = 7; reg_write_m = 1;
      #1 chk("fwd_d_alu", {30'd0, fwd_a_d, fwd_b_d}, 32'd3);
      mem_to_reg_m = 1;
      #1 chk("fwd_d_load", {30'd0, fwd_a_d, fwd_b_d}, 32'd0);
      clear_inputs();

      // Load-use
      step();
      mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8;
      #1 chk("lw_stall", ctl(), 32'b1100010);
      step();
      mem_to_reg_e = 0; write_reg_e = 0;
      #1 chk("lw_released", ctl(), 32'h00);
      mem_to_reg_e = 1; write_reg_e = 0; rt_d = 0; rs_d = 0;
      #1 chk("lw_r0", ctl(), 32'h00);
      clear_inputs();

      // Branch hazard, then forward from M, then taken
      step();
      branch_d = 1; rs_d = 3; reg_write_e = 1; write_reg_e = 3;
      #1 chk("br_stall", ctl(), 32'b1100010);
      step();
      reg_write_e = 0; write_reg_e = 0; reg_write_m = 1; write_reg_m = 3;
      #1 chk("br_fwd_a_d", 32'(fwd_a_d), 32'd1);
      chk("br_nostall", ctl(), 32'h00);
      branch_taken_d = 1;
      #1 chk("br_taken", ctl(), 32'b0000100);
      clear_inputs();

      // Memory wait of 4 stall cycles; a taken branch is masked while busy
      step();
      mem_req_m = 1; mem_ready_m = 0; branch_taken_d = 1;
      #1 chk("mw_c0", ctl(), 32'b1111001);
      for (int i = 1; i <= 3; i++) begin
         step();
         #1 chk($sformatf("mw_c%0d", i), ctl(), 32'b1111001);
      end
      step();
      mem_ready_m = 1;
      #1 chk("mw_ready", ctl(), 32'b0000100);
      step();
      clear_inputs();
      #1 chk("mw_run", ctl(), 32'h00);
      chk("mw_err", 32'(mem_err), 32'd0);
      mem_req_m = 1; mem_ready_m = 1;
      #1 chk("mw_single", ctl(), 32'h00);
      step();
      clear_inputs();
      #1 chk("mw_single_run", ctl(), 32'h00);

      // Timeout
      mem_req_m = 1; mem_ready_m = 0;
      #1 chk("to_c0", 32'(stall_f), 32'd1);
      for (int i = 1; i <= 15; i++) begin
         step();
         #1 chk($sformatf("to_c%0d", i), 32'(stall_f), 32'd1);
      end
      step();
      #1 chk("to_drop", ctl(), 32'h00);
      chk("to_err_pre", 32'(mem_err), 32'd0);
      mem_req_m = 0;
      step();
      #1 chk("to_err", 32'(mem_err), 32'd1);
      chk("to_run", ctl(), 32'h00);
      step();
      #1 chk("to_err_sticky", 32'(mem_err), 32'd1);

      // Reset in the middle of a wait
      mem_req_m = 1; mem_ready_m = 0;
      step(); step();
      #1 chk("rw_waiting", 32'(stall_m), 32'd1);
      rst = 1; mem_req_m = 0;
      step();
      #1 chk("rw_ctl", ctl(), 32'h00);
      chk("rw_err", 32'(mem_err), 32'd0);
      rst = 0;
      #1 chk("rw_run", ctl(), 32'h00);

      // Taken branch ignored under a load-use stall
      mem_to_reg_e = 1; write_reg_e = 9; rs_d = 9; branch_taken_d = 1;
      #1 chk("bt_masked", ctl(), 32'b1100010);
      clear_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
